// File: rtl/drvr_fifo_fwft_pkg.sv
// Shared definitions for the driver/bus staging logic: default sizes and the
// modulo pointer increment used by FIFOs, arbiter wrappers and tester top.
package drvr_bus_pkg;

  localparam int BITS_DEFAULT  = 256;
  localparam int DEPTH_DEFAULT = 16;

  // Wraps depth-1 back to 0 with an explicit compare so any depth >= 2 works.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/drvr_fifo_fwft_if.sv
// Producer/consumer handshake bundle for one driver staging FIFO.
interface drvr_fifo_fwft_if
  import drvr_bus_pkg::*;
#(
  parameter int bits  = BITS_DEFAULT,
  parameter int depth = DEPTH_DEFAULT
) ();

  logic                           push;
  logic [bits-1:0]                D_push;
  logic                           pop;
  logic [bits-1:0]                D_pop;
  logic                           pndng;
  logic                           full;
  logic [$clog2(depth+1)-1:0]     count;
  logic                           overflow;
  logic                           underflow;

  modport master (
    output push, D_push, pop,
    input  D_pop, pndng, full, count, overflow, underflow
  );

  modport slave (
    input  push, D_push, pop,
    output D_pop, pndng, full, count, overflow, underflow
  );

endinterface

// File: rtl/drvr_fifo_fwft_wrap_ptr.sv
// Registered FIFO pointer that advances on enable and wraps modulo depth.
module fifo_wrap_ptr
  import drvr_bus_pkg::*;
#(
  parameter int depth = DEPTH_DEFAULT,
  parameter int PW    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_ptr <= '0;
    else if (i_en) r_ptr <= PW'(ptr_inc(32'(r_ptr), depth));
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/drvr_fifo_fwft.sv
// First-word-fall-through staging FIFO between a channel tester and the bus arbiter.
// Status flags are registered from next-state values; D_pop is the registered head.
module drvr_fifo_fwft
  import drvr_bus_pkg::*;
#(
  parameter int bits  = BITS_DEFAULT,
  parameter int depth = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  drvr_fifo_fwft_if.slave bus
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  logic [bits-1:0] r_mem [0:depth-1];
  logic [CW-1:0]   r_count;
  logic            r_pndng;
  logic            r_full;
  logic            r_overflow;
  logic            r_underflow;

  logic            w_rd_en;
  logic            w_wr_en;
  logic [PW-1:0]   w_rd_ptr;
  logic [PW-1:0]   w_wr_ptr;
  logic [CW-1:0]   w_count_nxt;

  // A pop frees a slot in the same edge, so a full FIFO may still accept a push.
  assign w_rd_en = bus.pop & r_pndng;
  assign w_wr_en = bus.push & (~r_full | w_rd_en);

  fifo_wrap_ptr #(.depth(depth), .PW(PW)) u_rd_ptr (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (w_rd_en),
    .o_ptr   (w_rd_ptr)
  );

  fifo_wrap_ptr #(.depth(depth), .PW(PW)) u_wr_ptr (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (w_wr_en),
    .o_ptr   (w_wr_ptr)
  );

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_en && !w_rd_en)      w_count_nxt = r_count + CW'(1);
    else if (w_rd_en && !w_wr_en) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_pndng     <= 1'b0;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_pndng <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CW'(depth));
      if (bus.push && !w_wr_en) r_overflow  <= 1'b1;
      if (bus.pop && !r_pndng)  r_underflow <= 1'b1;
    end
  end

  // Storage carries no reset; only occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_ptr] <= bus.D_push;
  end

  assign bus.D_pop     = r_pndng ? r_mem[w_rd_ptr] : '0;
  assign bus.pndng     = r_pndng;
  assign bus.full      = r_full;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_drvr_fifo_fwft.sv
// Drives a depth-4 and a depth-5 FIFO with identical stimulus and compares both
// against queue-based reference models every cycle.
module tb_drvr_fifo_fwft;

  localparam int BITS = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  drvr_fifo_fwft_if #(.bits(BITS), .depth(4)) if4 ();
  drvr_fifo_fwft_if #(.bits(BITS), .depth(5)) if5 ();

  drvr_fifo_fwft #(.bits(BITS), .depth(4)) u_dut4 (.clk(clk), .reset(rst_n), .bus(if4));
  drvr_fifo_fwft #(.bits(BITS), .depth(5)) u_dut5 (.clk(clk), .reset(rst_n), .bus(if5));

  logic [BITS-1:0] obs_d   [2];
  logic            obs_pnd [2];
  logic            obs_ful [2];
  logic [2:0]      obs_cnt [2];
  logic            obs_ovf [2];
  logic            obs_unf [2];

  assign obs_d[0]   = if4.D_pop;     assign obs_d[1]   = if5.D_pop;
  assign obs_pnd[0] = if4.pndng;     assign obs_pnd[1] = if5.pndng;
  assign obs_ful[0] = if4.full;      assign obs_ful[1] = if5.full;
  assign obs_cnt[0] = if4.count;     assign obs_cnt[1] = if5.count;
  assign obs_ovf[0] = if4.overflow;  assign obs_ovf[1] = if5.overflow;
  assign obs_unf[0] = if4.underflow; assign obs_unf[1] = if5.underflow;

  logic [BITS-1:0] mq [2][$];
  int              mdepth [2] = '{4, 5};
  bit              movf [2];
  bit              munf [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
      munf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit p, input bit q, input logic [BITS-1:0] d);
    for (int k = 0; k < 2; k++) begin
      int  sz;
      bit  rd, wr;
      sz = mq[k].size();
      rd = q && (sz > 0);
      wr = p && ((sz < mdepth[k]) || rd);
      if (q && sz == 0) munf[k] = 1'b1;
      if (p && !wr)     movf[k] = 1'b1;
      if (rd) void'(mq[k].pop_front());
      if (wr) mq[k].push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic [BITS-1:0] exp_d;
      int sz;
      sz    = mq[k].size();
      exp_d = (sz != 0) ? mq[k][0] : '0;
      chk($sformatf("%s_d%0d_dpop", tag, mdepth[k]), obs_d[k], exp_d);
      chk($sformatf("%s_d%0d_pndng", tag, mdepth[k]), BITS'(obs_pnd[k]), BITS'(sz != 0));
      chk($sformatf("%s_d%0d_full", tag, mdepth[k]), BITS'(obs_ful[k]), BITS'(sz == mdepth[k]));
      chk($sformatf("%s_d%0d_count", tag, mdepth[k]), BITS'(obs_cnt[k]), BITS'(sz));
      chk($sformatf("%s_d%0d_ovf", tag, mdepth[k]), BITS'(obs_ovf[k]), BITS'(movf[k]));
      chk($sformatf("%s_d%0d_unf", tag, mdepth[k]), BITS'(obs_unf[k]), BITS'(munf[k]));
    end
  endtask

  task automatic set_in(input bit p, input bit q, input logic [BITS-1:0] d);
    if4.push = p; if4.pop = q; if4.D_push = d;
    if5.push = p; if5.pop = q; if5.D_push = d;
  endtask

  // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
  task automatic cycle(input string tag, input bit p, input bit q, input logic [BITS-1:0] d);
    set_in(p, q, d);
    @(posedge clk);
    model_step(p, q, d);
    @(negedge clk);
    set_in(1'b0, 1'b0, '0);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    set_in(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [BITS-1:0] rand_word();
    logic [BITS-1:0] w;
    for (int i = 0; i < BITS / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    int maxc;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, '0);
    model_clear();
    repeat (2) @(negedge clk);
    check_all("rst");
    rst_n = 1'b1;

    // Single word in and out.
    cycle("t1_push", 1'b1, 1'b0, BITS'(8'hA5));
    chk("t1_dpop_a5", if4.D_pop, BITS'(8'hA5));
    chk("t1_count1", BITS'(if4.count), BITS'(1));
    cycle("t1_pop", 1'b0, 1'b1, '0);
    chk("t1_empty", BITS'(if4.pndng), BITS'(0));
    chk("t1_dpop_zero", if4.D_pop, '0);

    // Fill, overflow, drain.
    do_reset("t2_rst");
    for (int i = 1; i <= 4; i++) cycle("t2_fill", 1'b1, 1'b0, BITS'(i));
    chk("t2_full", BITS'(if4.full), BITS'(1));
    cycle("t2_ovf", 1'b1, 1'b0, BITS'(5));
    chk("t2_ovf_flag", BITS'(if4.overflow), BITS'(1));
    chk("t2_ovf_count", BITS'(if4.count), BITS'(4));
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t2_order%0d", i), if4.D_pop, BITS'(i));
      cycle("t2_drain", 1'b0, 1'b1, '0);
    end

    // Push and pop together while full.
    do_reset("t3_rst");
    for (int i = 1; i <= 4; i++) cycle("t3_fill", 1'b1, 1'b0, BITS'(i));
    cycle("t3_both", 1'b1, 1'b1, BITS'(9));
    chk("t3_dpop2", if4.D_pop, BITS'(2));
    chk("t3_full", BITS'(if4.full), BITS'(1));
    chk("t3_noovf", BITS'(if4.overflow), BITS'(0));
    for (int i = 0; i < 4; i++) cycle("t3_drain", 1'b0, 1'b1, '0);

    // Pop on empty with simultaneous push.
    do_reset("t4_rst");
    cycle("t4_both", 1'b1, 1'b1, BITS'(7));
    chk("t4_unf", BITS'(if4.underflow), BITS'(1));
    chk("t4_dpop7", if4.D_pop, BITS'(7));

    // Continuous streaming through the wrap point.
    do_reset("t5_rst");
    maxc = 0;
    cycle("t5_first", 1'b1, 1'b0, BITS'(0));
    for (int i = 1; i < 12; i++) begin
      if (int'(if5.count) > maxc) maxc = int'(if5.count);
      cycle("t5_stream", 1'b1, 1'b1, BITS'(i));
    end
    cycle("t5_last", 1'b0, 1'b1, '0);
    chk("t5_maxcnt_le2", BITS'(maxc <= 2), BITS'(1));

    // Asynchronous reset between edges.
    do_reset("t6_rst");
    for (int i = 0; i < 3; i++) cycle("t6_fill", 1'b1, 1'b0, rand_word());
    #2;
    do_reset("t6_async");
    cycle("t6_after", 1'b1, 1'b0, BITS'(8'h55));
    chk("t6_dpop55", if4.D_pop, BITS'(8'h55));

    // Random traffic with varying push/pop bias.
    do_reset("rnd_rst");
    for (int n = 0; n < 1500; n++) begin
      int bias;
      bias = (n / 250) % 3;
      cycle("rnd",
            ($urandom_range(0, 9) < (bias == 0 ? 8 : bias == 1 ? 3 : 5)),
            ($urandom_range(0, 9) < (bias == 0 ? 3 : bias == 1 ? 8 : 5)),
            rand_word());
      if (n == 900) do_reset("rnd_mid_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
